// File: rtl/rv32i_imem_loader.sv
// Boot-time instruction memory writer: takes a byte stream carrying a
// little-endian word count followed by little-endian instruction words and
// writes them to word-aligned byte addresses.
// The core is held in reset while a load is in progress or after a rejected load.
module rv32i_imem_loader #(
  parameter int INSTR_MEM_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_rst_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [INSTR_MEM_WIDTH:0] IDX_ONE   = 1;
  localparam logic [32:0]              MAX_WORDS = 33'd1 << INSTR_MEM_WIDTH;

  state_t                   state, state_nxt;
  logic [1:0]               b;
  logic [23:0]              len_lo;
  logic [INSTR_MEM_WIDTH:0] n_words;
  logic [INSTR_MEM_WIDTH:0] idx;
  logic [23:0]              word_p0;

  logic                     accept;
  logic                     last_byte;
  logic                     restart;
  logic [31:0]              len_final;
  logic [INSTR_MEM_WIDTH:0] idx_inc;
  logic                     busy_nxt, done_nxt, error_nxt, core_rst_n_nxt;

  // A word count equal to the memory depth is legal; anything above is not.
  function automatic logic len_too_big(input logic [31:0] n);
    return {1'b0, n} > MAX_WORDS;
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (b == 2'd3);
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign len_final = {in_data, len_lo};
  assign idx_inc   = idx + IDX_ONE;

  // State register with status flags registered alongside it (glitch-free)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b1;
    end else begin
      state      <= state_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      core_rst_n <= core_rst_n_nxt;
    end
  end

  // Next-state logic; start is only honoured outside LEN/DATA
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (last_byte) begin
          if (len_final == 32'd0)          state_nxt = S_DONE;
          else if (len_too_big(len_final)) state_nxt = S_ERROR;
          else                             state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte && (idx_inc == n_words)) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: in_ready from current state, flags from next state
  always_comb begin
    in_ready       = (state == S_LEN) || (state == S_DATA);
    busy_nxt       = (state_nxt == S_LEN) || (state_nxt == S_DATA);
    done_nxt       = (state_nxt == S_DONE);
    error_nxt      = (state_nxt == S_ERROR);
    core_rst_n_nxt = (state_nxt == S_IDLE) || (state_nxt == S_DONE);
  end

  // Byte assembly and the registered memory write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b         <= 2'd0;
      idx       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        b   <= 2'd0;
        idx <= '0;
      end
      if (accept) begin
        b <= b + 2'd1;
        if (state == S_LEN) begin
          case (b)
            2'd0:    len_lo[7:0]   <= in_data;
            2'd1:    len_lo[15:8]  <= in_data;
            2'd2:    len_lo[23:16] <= in_data;
            default: n_words       <= len_final[INSTR_MEM_WIDTH:0];
          endcase
        end else begin
          case (b)
            2'd0:    word_p0[7:0]   <= in_data;
            2'd1:    word_p0[15:8]  <= in_data;
            2'd2:    word_p0[23:16] <= in_data;
            default: begin
              mem_we    <= 1'b1;
              mem_addr  <= {{(30-INSTR_MEM_WIDTH){1'b0}}, idx[INSTR_MEM_WIDTH-1:0], 2'b00};
              mem_wdata <= {in_data, word_p0};
              idx       <= idx_inc;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Self-checking bench for rv32i_imem_loader: transaction-level model of the
// expected outputs, compared against the DUT on every falling edge.
module tb_rv32i_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, error, core_rst_n;
  logic [31:0] mem_addr, mem_wdata;

  rv32i_imem_loader #(.INSTR_MEM_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .core_rst_n(core_rst_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 0;

  // expected output values (the model)
  logic        e_we, e_busy, e_done, e_err, e_core;
  logic [31:0] e_addr, e_data;

  // observed writes
  int          wr_cnt = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] last_addr = 32'hFFFF_FFFF;
  logic [31:0] words [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready",   32'(in_ready),   32'(e_busy));
      chk("mem_we",     32'(mem_we),     32'(e_we));
      chk("mem_addr",   mem_addr,        e_addr);
      chk("mem_wdata",  mem_wdata,       e_data);
      chk("busy",       32'(busy),       32'(e_busy));
      chk("done",       32'(done),       32'(e_done));
      chk("error",      32'(error),      32'(e_err));
      chk("core_rst_n", 32'(core_rst_n), 32'(e_core));
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      mem[mem_addr[11:2]] = mem_wdata;
      last_addr = mem_addr;
    end
  end

  task automatic model_reset();
    e_we = 0; e_busy = 0; e_done = 0; e_err = 0; e_core = 1;
    e_addr = 0; e_data = 0;
  endtask

  // advance one clock; a write pulse lasts exactly one cycle
  task automatic cyc();
    @(posedge clk);
    #1;
    e_we = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) cyc();
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap, input bit with_start);
    in_valid = 0;
    repeat (gap) begin
      in_data = 8'($urandom);
      cyc();
    end
    in_valid = 1;
    in_data  = v;
    start    = with_start;
    cyc();
    in_valid = 0;
    start    = 0;
  endtask

  task automatic start_pulse();
    start = 1;
    cyc();
    start = 0;
    if (!e_busy) begin
      e_busy = 1; e_done = 0; e_err = 0; e_core = 0;
    end
  endtask

  // One load: length field n, payload from 'words'; optional start pulse
  // during data and optional reset after 'abort_after' data bytes.
  task automatic do_load(input logic [31:0] n, input int gmax,
                         input bit start_mid, input int abort_after);
    int sent;
    logic [31:0] w;
    sent = 0;
    start_pulse();
    for (int k = 0; k < 4; k++)
      send_byte(n[8*k +: 8], $urandom_range(0, gmax), 0);
    if (n == 0) begin
      e_busy = 0; e_done = 1; e_core = 1;
    end else if (n > 32'd1024) begin
      e_busy = 0; e_err = 1;
    end
    if (!e_busy) return;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        if (sent == abort_after) begin
          rst_n = 0;
          cyc();
          model_reset();
          rst_n = 1;
          return;
        end
        send_byte(w[8*k +: 8], $urandom_range(0, gmax), start_mid && i == 1 && k == 1);
        sent++;
      end
      e_we = 1; e_addr = 32'(i) << 2; e_data = w;
      if (i == words.size() - 1) begin
        e_busy = 0; e_done = 1; e_core = 1;
      end
    end
  endtask

  initial begin
    int c0;
    rst_n = 0; start = 0; in_valid = 0; in_data = 0;
    model_reset();
    cyc();
    checking = 1;
    cyc();
    rst_n = 1;
    idle(2);

    // 1: two-word load without gaps
    c0 = wr_cnt;
    words = '{32'h00100513, 32'h00200593};
    do_load(32'd2, 0, 0, -1);
    idle(2);
    chk("t1_writes", 32'(wr_cnt - c0), 32'd2);
    chk("t1_word0", mem[0], 32'h00100513);
    chk("t1_word1", mem[1], 32'h00200593);
    chk("t1_done", 32'(done), 32'd1);

    // 2: same stream with random gaps
    c0 = wr_cnt;
    do_load(32'd2, 5, 0, -1);
    idle(2);
    chk("t2_writes", 32'(wr_cnt - c0), 32'd2);
    chk("t2_last_addr", last_addr, 32'h4);

    // 3a: zero length
    c0 = wr_cnt;
    words = {};
    do_load(32'd0, 2, 0, -1);
    idle(2);
    chk("t3_zero_writes", 32'(wr_cnt - c0), 32'd0);

    // 3b: full depth
    c0 = wr_cnt;
    words = {};
    for (int i = 0; i < 1024; i++) words.push_back($urandom);
    do_load(32'd1024, 0, 0, -1);
    idle(2);
    chk("t3_max_writes", 32'(wr_cnt - c0), 32'd1024);
    chk("t3_max_last", last_addr, 32'hFFC);
    chk("t3_max_word", mem[1023], words[1023]);

    // 4: oversize then clean restart
    c0 = wr_cnt;
    words = {};
    do_load(32'h0000_0401, 1, 0, -1);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      cyc();
    end
    in_valid = 0;
    chk("t4_writes", 32'(wr_cnt - c0), 32'd0);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_core_rst", 32'(core_rst_n), 32'd0);
    words = '{$urandom, $urandom, $urandom};
    do_load(32'd3, 3, 0, -1);
    idle(2);
    chk("t4_restart_writes", 32'(wr_cnt - c0), 32'd3);

    // 5: start pulsed during DATA is ignored
    c0 = wr_cnt;
    words = '{$urandom, $urandom, $urandom, $urandom};
    do_load(32'd4, 2, 1, -1);
    idle(2);
    chk("t5_writes", 32'(wr_cnt - c0), 32'd4);
    chk("t5_word3", mem[3], words[3]);

    // 6: reset after 6 data bytes of a 3-word load
    c0 = wr_cnt;
    words = '{$urandom, $urandom, $urandom};
    do_load(32'd3, 1, 0, 6);
    idle(3);
    chk("t6_writes", 32'(wr_cnt - c0), 32'd1);
    chk("t6_last_addr", last_addr, 32'h0);
    chk("t6_idle_core", 32'(core_rst_n), 32'd1);

    // random short loads
    for (int r = 0; r < 4; r++) begin
      int nw;
      nw = $urandom_range(1, 6);
      c0 = wr_cnt;
      words = {};
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      do_load(32'(nw), 4, 0, -1);
      idle(2);
      chk("rand_writes", 32'(wr_cnt - c0), 32'(nw));
    end

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_imem_loader.md
Name: rv32i_imem_loader

Overview:
- Boot-time writer for the instruction memory: accepts a byte stream (e.g. from the UART receiver), assembles little-endian 32-bit words and drives the instruction memory write port with word-aligned byte addresses.
- The core reads instruction memory through the PC only. This block is the write side of that storage.
- Holds the core in reset while a load is in progress or has failed.

Parameters:
INSTR_MEM_WIDTH, 10, word-index width; instruction memory depth = 2**INSTR_MEM_WIDTH words.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse: begin a new load
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable, one cycle per word
mem_addr  output  32  byte address of the write, bits [1:0] always 0
mem_wdata  output  32  assembled instruction word
busy  output  1  load in progress (states LEN, DATA)
done  output  1  last load completed successfully; held until next start
error  output  1  last load rejected (length too large); held until next start
core_rst_n  output  1  active-low reset to core; 0 while busy or error

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0, core_rst_n=1.
  - In IDLE the core runs the preloaded image.
- Handshake: a byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_ready is 1 only in LEN and DATA, combinational from state. in_valid gaps of any length are allowed.
- Byte order: the byte counter b (0..3) places the byte into bits [8b+7:8b]. b wraps from 3 to 0.
- States:
  - IDLE: start=1 -> LEN, clear b, word index, done and error.
  - LEN: collect 4 bytes into length N (words, little-endian).
    - On the 4th byte, N=0 -> DONE.
    - N > 2**INSTR_MEM_WIDTH -> ERROR.
    - Otherwise -> DATA with word index i=0.
  - DATA: collect 4 bytes per word.
    - On the 4th byte, next cycle: mem_we=1, mem_addr={i,2'b00} zero-extended to 32 bits, mem_wdata=assembled word. Write latency is 1 cycle after acceptance of the 4th byte.
    - i increments. When i reaches N -> DONE, in the same cycle that mem_we is asserted for the final word.
  - DONE: done=1, core_rst_n=1, in_ready=0. start -> LEN.
  - ERROR: error=1, core_rst_n=0, in_ready=0, no writes. start -> LEN.
- start while busy (LEN or DATA) is ignored.
- mem_we is never asserted in IDLE, LEN, ERROR, or for more than one cycle per word.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- N = 2**INSTR_MEM_WIDTH is legal. The last write is to word index 2**INSTR_MEM_WIDTH-1, with no wrap of i before DONE.
- Reset mid-load: writes stop immediately (mem_we=0 from the next edge). Partial words are discarded. Words already written stay in memory.
- core_rst_n = 0 in LEN, DATA and ERROR; 1 in IDLE and DONE. It is registered with the state, so there are no glitches.

Test Plan:
1. Load, no gaps: start; stream 02 00 00 00, 13 05 10 00, 93 05 20 00 -> mem_we pulses twice: (addr 0x0, data 0x00100513), (addr 0x4, data 0x00200593). Then done=1, busy=0, core_rst_n=1.
2. Backpressure/gaps: same stream with in_valid low for 0–5 random cycles between bytes -> identical writes. Each write is 1 cycle after its 4th byte.
3. Zero and max length: N=0 -> DONE right after 4 bytes, no mem_we. N=1024 (width 10) -> 1024 writes, last at addr 0xFFC, then done.
4. Oversize: N=0x00000401 -> error=1, core_rst_n=0, in_ready=0, no mem_we. A following start restarts cleanly into LEN.
5. start pulsed during DATA -> ignored. Word index and byte position unchanged and the load completes normally.
6. rst_n low after 6 data bytes of a 3-word load -> exactly one write observed (addr 0x0). After reset all outputs are at reset values and state is IDLE.
